// File: rtl/parallel_rmw_bridge_pkg.sv
// Shared definitions for the parallel-interface request bridge:
// FSM state encodings and byte-lane geometry.
package parallel_rmw_bridge_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int LANES      = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD      = 3'd1,
        ST_WR      = 3'd2,
        ST_RMW_RD  = 3'd3,
        ST_RMW_GAP = 3'd4,
        ST_RMW_WR  = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

endpackage

// File: rtl/parallel_rmw_bridge_byte_lane_merge.sv
// Combinational byte-lane merge: each lane takes the new word where its
// enable is set, otherwise keeps the old word.
module byte_lane_merge
    import parallel_rmw_bridge_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] old_word,
    input  logic [DATA_WIDTH-1:0] new_word,
    input  logic [LANES-1:0]      be,
    output logic [DATA_WIDTH-1:0] merged
);

    // Per-lane select between old and new data
    always_comb begin
        merged = old_word;
        for (int i = 0; i < LANES; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                merged[8*i +: 8] = old_word[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/parallel_rmw_bridge.sv
// CPU-side bridge onto the 32-bit parallel device bus port: serialises
// byte-enabled requests into whole-word transactions, using read-modify-write for partial writes.
module parallel_rmw_bridge
    import parallel_rmw_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = 24,
    parameter bit RMW_ENABLE = 1'b1
) (
    input  logic                  clk_bus,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] cpu_address,
    input  logic [31:0]           cpu_data_i,
    input  logic [3:0]            cpu_byte_en,
    input  logic                  cpu_read,
    input  logic                  cpu_write,
    output logic [31:0]           cpu_data_o,
    output logic                  cpu_stall,
    output logic [ADDR_WIDTH-1:0] ifce_address,
    output logic [31:0]           ifce_data_o,
    output logic                  ifce_read,
    output logic                  ifce_write,
    input  logic [31:0]           ifce_data_i,
    input  logic                  ifce_stall
);

    state_t                state_r;
    state_t                state_s;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [31:0]           data_r;
    logic [3:0]            be_r;
    logic [31:0]           cpu_data_r;
    logic                  ifce_read_r;
    logic                  ifce_write_r;
    logic                  accept_s;
    logic                  complete_s;
    logic [31:0]           merged_s;

    assign accept_s   = (state_r == ST_IDLE) & (cpu_read | cpu_write);
    assign complete_s = (ifce_read_r | ifce_write_r) & ~ifce_stall;
    assign cpu_stall  = (cpu_read | cpu_write) & (state_r != ST_DONE);

    assign cpu_data_o   = cpu_data_r;
    assign ifce_address = addr_r;
    assign ifce_data_o  = data_r;
    assign ifce_read    = ifce_read_r;
    assign ifce_write   = ifce_write_r;

    byte_lane_merge u_merge (
        .old_word (ifce_data_i),
        .new_word (data_r),
        .be       (be_r),
        .merged   (merged_s)
    );

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cpu_read) begin
                    state_s = ST_RD;
                end else if (cpu_write) begin
                    // An empty lane mask is acknowledged without touching the device
                    if (cpu_byte_en == 4'h0) begin
                        state_s = ST_DONE;
                    end else if ((cpu_byte_en == 4'hF) || (RMW_ENABLE == 1'b0)) begin
                        state_s = ST_WR;
                    end else begin
                        state_s = ST_RMW_RD;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RD, ST_WR, ST_RMW_WR: begin
                if (complete_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = state_r;
                end
            end
            ST_RMW_RD: begin
                if (complete_s) begin
                    state_s = ST_RMW_GAP;
                end else begin
                    state_s = ST_RMW_RD;
                end
            end
            ST_RMW_GAP: state_s = ST_RMW_WR;
            ST_DONE:    state_s = ST_IDLE;
            default:    state_s = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_bus or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Latched request, merged word, read return and registered bus strobes
    always_ff @(posedge clk_bus or negedge rst_n) begin
        if (!rst_n) begin
            addr_r       <= {ADDR_WIDTH{1'b0}};
            data_r       <= 32'h0000_0000;
            be_r         <= 4'h0;
            cpu_data_r   <= 32'h0000_0000;
            ifce_read_r  <= 1'b0;
            ifce_write_r <= 1'b0;
        end else begin
            if (accept_s) begin
                addr_r <= cpu_address;
                data_r <= cpu_data_i;
                be_r   <= cpu_byte_en;
            end else if ((state_r == ST_RMW_RD) && complete_s) begin
                data_r <= merged_s;
            end
            if ((state_r == ST_RD) && complete_s) begin
                cpu_data_r <= ifce_data_i;
            end
            // Strobes follow the next state, so they drop the cycle after completion
            ifce_read_r  <= (state_s == ST_RD) || (state_s == ST_RMW_RD);
            ifce_write_r <= (state_s == ST_WR) || (state_s == ST_RMW_WR);
        end
    end

endmodule

// File: tb/tb_parallel_rmw_bridge.sv
// Directed bench for parallel_rmw_bridge with a behavioural device that
// completes each request after a fixed hold of 4 cycles.
`define CHK(tag, obs, exp) begin checks++; assert ((obs) === (exp)) else begin failures++; $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); end end

module tb_parallel_rmw_bridge;
    import parallel_rmw_bridge_pkg::*;

    localparam int HOLD = 4;

    logic        clk_bus = 1'b0;
    logic        rst_n   = 1'b0;
    logic [23:0] cpu_address = 24'h0;
    logic [31:0] cpu_data_i  = 32'h0;
    logic [3:0]  cpu_byte_en = 4'h0;
    logic        cpu_read    = 1'b0;
    logic        cpu_write   = 1'b0;
    logic [31:0] cpu_data_o;
    logic        cpu_stall;
    logic [23:0] ifce_address;
    logic [31:0] ifce_data_o;
    logic        ifce_read;
    logic        ifce_write;
    logic [31:0] ifce_data_i;
    logic        ifce_stall;

    int checks   = 0;
    int failures = 0;

    // device model state
    logic [31:0] mem [0:255];
    int          cnt = 0;
    int          rd_txn = 0, wr_txn = 0, req_cycles = 0, gap_err = 0, addr_err = 0;
    logic        prev_done = 1'b0;
    logic        pre_en = 1'b0;
    logic [7:0]  pre_addr = 8'h0;
    logic [31:0] pre_data = 32'h0;
    logic        req;

    always #5 clk_bus = ~clk_bus;

    parallel_rmw_bridge dut (
        .clk_bus      (clk_bus),
        .rst_n        (rst_n),
        .cpu_address  (cpu_address),
        .cpu_data_i   (cpu_data_i),
        .cpu_byte_en  (cpu_byte_en),
        .cpu_read     (cpu_read),
        .cpu_write    (cpu_write),
        .cpu_data_o   (cpu_data_o),
        .cpu_stall    (cpu_stall),
        .ifce_address (ifce_address),
        .ifce_data_o  (ifce_data_o),
        .ifce_read    (ifce_read),
        .ifce_write   (ifce_write),
        .ifce_data_i  (ifce_data_i),
        .ifce_stall   (ifce_stall)
    );

    assign req         = ifce_read | ifce_write;
    assign ifce_stall  = req & (cnt != HOLD);
    assign ifce_data_i = mem[ifce_address[7:0]];

    // Device: completes after HOLD waiting cycles, flags a request held through the gap
    always @(posedge clk_bus) begin
        if (pre_en) mem[pre_addr] <= pre_data;
        if (req) begin
            req_cycles <= req_cycles + 1;
            if (ifce_address[23:8] != 16'h0) addr_err <= addr_err + 1;
            if (prev_done) gap_err <= gap_err + 1;
            if (cnt == HOLD) begin
                cnt <= 0;
                if (ifce_write) begin
                    mem[ifce_address[7:0]] <= ifce_data_o;
                    wr_txn <= wr_txn + 1;
                end else begin
                    rd_txn <= rd_txn + 1;
                end
            end else begin
                cnt <= cnt + 1;
            end
        end else begin
            cnt <= 0;
        end
        prev_done <= req && (cnt == HOLD);
    end

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk_bus);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk_bus);
        pre_en = 1'b0;
    endtask

    // Issue one CPU request and count stalled cycles until cpu_stall drops
    task automatic cpu_op(input logic rd, input logic wr, input logic [23:0] addr,
                          input logic [31:0] data, input logic [3:0] be,
                          input logic b2b, input logic release_after,
                          output logic [31:0] rdata, output int stalls);
        int guard;
        if (!b2b) @(negedge clk_bus);
        cpu_read = rd; cpu_write = wr; cpu_address = addr;
        cpu_data_i = data; cpu_byte_en = be;
        if (b2b) @(negedge clk_bus);
        #1;
        stalls = 0; guard = 0;
        while (cpu_stall === 1'b1 && guard < 200) begin
            stalls++; guard++;
            @(negedge clk_bus);
            cpu_address = addr ^ 24'h000004;
            cpu_data_i  = ~data;
            cpu_byte_en = ~be;
            #1;
        end
        `CHK("op_timeout", (guard < 200), 1'b1)
        rdata = cpu_data_o;
        if (release_after) begin
            cpu_read = 1'b0; cpu_write = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] rdata;
        int stalls, rd0, wr0, rq0;

        for (int i = 0; i < 256; i++) begin
            preload(i[7:0], 32'h0);
            if (i >= 3) break;
        end
        preload(8'h10, 32'hDEAD_BEEF);
        preload(8'h30, 32'hAABB_CCDD);
        preload(8'h40, 32'h5566_7788);
        preload(8'h50, 32'hCAFE_F00D);
        preload(8'h60, 32'h0102_0304);
        preload(8'h20, 32'h0000_0000);
        preload(8'h64, 32'h0000_0000);

        #1;
        `CHK("rst_ifce_read", ifce_read, 1'b0)
        `CHK("rst_ifce_write", ifce_write, 1'b0)
        `CHK("rst_ifce_address", ifce_address, 24'h0)
        `CHK("rst_ifce_data_o", ifce_data_o, 32'h0)
        `CHK("rst_cpu_data_o", cpu_data_o, 32'h0)
        `CHK("rst_cpu_stall", cpu_stall, 1'b0)
        @(negedge clk_bus);
        rst_n = 1'b1;

        // full read
        rd0 = rd_txn; wr0 = wr_txn;
        cpu_op(1'b1, 1'b0, 24'h000010, 32'h0, 4'h0, 1'b0, 1'b1, rdata, stalls);
        `CHK("rd_data", rdata, 32'hDEAD_BEEF)
        `CHK("rd_stalls", stalls, 6)
        `CHK("rd_txn_count", rd_txn - rd0, 1)
        `CHK("rd_no_write", wr_txn - wr0, 0)

        // full write
        rd0 = rd_txn; wr0 = wr_txn;
        cpu_op(1'b0, 1'b1, 24'h000020, 32'h1234_5678, 4'hF, 1'b0, 1'b1, rdata, stalls);
        `CHK("wr_stalls", stalls, 6)
        `CHK("wr_mem", mem[8'h20], 32'h1234_5678)
        `CHK("wr_no_read", rd_txn - rd0, 0)
        `CHK("wr_txn_count", wr_txn - wr0, 1)
        `CHK("wr_holds_cpu_data_o", cpu_data_o, 32'hDEAD_BEEF)

        // partial write via read-modify-write
        rd0 = rd_txn; wr0 = wr_txn;
        cpu_op(1'b0, 1'b1, 24'h000030, 32'h1122_3344, 4'b0101, 1'b0, 1'b1, rdata, stalls);
        `CHK("rmw_stalls", stalls, 12)
        `CHK("rmw_mem", mem[8'h30], 32'hAA22_CC44)
        `CHK("rmw_rd_count", rd_txn - rd0, 1)
        `CHK("rmw_wr_count", wr_txn - wr0, 1)
        `CHK("rmw_gap", gap_err, 0)

        // empty lane mask
        rq0 = req_cycles;
        cpu_op(1'b0, 1'b1, 24'h000040, 32'hFFFF_FFFF, 4'h0, 1'b0, 1'b1, rdata, stalls);
        `CHK("be0_stalls", stalls, 1)
        @(negedge clk_bus);
        `CHK("be0_no_request", req_cycles - rq0, 0)
        `CHK("be0_mem", mem[8'h40], 32'h5566_7788)

        // back-to-back read then write with request held
        rd0 = rd_txn; wr0 = wr_txn;
        cpu_op(1'b1, 1'b0, 24'h000060, 32'h0, 4'h0, 1'b0, 1'b0, rdata, stalls);
        `CHK("b2b_rd_data", rdata, 32'h0102_0304)
        `CHK("b2b_rd_stalls", stalls, 6)
        `CHK("b2b_gap_idle", req, 1'b0)
        cpu_op(1'b0, 1'b1, 24'h000064, 32'hA5A5_A5A5, 4'hF, 1'b1, 1'b1, rdata, stalls);
        `CHK("b2b_wr_stalls", stalls, 6)
        `CHK("b2b_wr_mem", mem[8'h64], 32'hA5A5_A5A5)
        `CHK("b2b_rd_count", rd_txn - rd0, 1)
        `CHK("b2b_wr_count", wr_txn - wr0, 1)
        `CHK("b2b_gap", gap_err, 0)

        // reset while the RMW read is pending
        wr0 = wr_txn;
        @(negedge clk_bus);
        cpu_write = 1'b1; cpu_address = 24'h000050;
        cpu_data_i = 32'hFFFF_FFFF; cpu_byte_en = 4'b0011;
        @(negedge clk_bus);
        #1;
        `CHK("rstmid_read_active", ifce_read, 1'b1)
        rst_n = 1'b0;
        #1;
        `CHK("rstmid_read_drop", ifce_read, 1'b0)
        `CHK("rstmid_write_low", ifce_write, 1'b0)
        cpu_write = 1'b0;
        @(negedge clk_bus);
        @(negedge clk_bus);
        rst_n = 1'b1;
        repeat (8) @(negedge clk_bus);
        #1;
        `CHK("rstmid_mem", mem[8'h50], 32'hCAFE_F00D)
        `CHK("rstmid_no_write", wr_txn - wr0, 0)
        `CHK("rstmid_idle", dut.state_r, ST_IDLE)
        `CHK("rstmid_cpu_data_o", cpu_data_o, 32'h0)

        // normal operation after reset
        cpu_op(1'b1, 1'b0, 24'h000030, 32'h0, 4'h0, 1'b0, 1'b1, rdata, stalls);
        `CHK("post_rst_rd", rdata, 32'hAA22_CC44)
        `CHK("addr_range", addr_err, 0)

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
